game_event_generator: RTL and testbench

Producer end of the game event handshake. Converts held-key levels from the PS/2 keyboard decoder and a level-dependent gravity timer into sticky event bits on `event_out`. Each bit stays set until the game FSM returns the matching `event_received` bit. The block sits in the `main_clk` domain between the keyboard decoder and the game state machine.

---
 rtl/game_event_generator_pkg.sv | 19 +
 rtl/game_event_generator_if.sv | 27 ++
 rtl/game_event_generator_key_repeat.sv | 58 +++++
 rtl/game_event_generator.sv | 101 ++++++++++
 tb/tb_game_event_generator.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/game_event_generator_pkg.sv
// rtl/game_event_generator_pkg.sv - shared event bit indices and key_repeat state type
package game_event_generator_pkg;

  localparam int EVENT_KEY_UP    = 0;
  localparam int EVENT_KEY_DOWN  = 1;
  localparam int EVENT_KEY_RIGHT = 2;
  localparam int EVENT_KEY_LEFT  = 3;
  localparam int EVENT_KEY_SPACE = 4;
  localparam int EVENT_FALL      = 5;
  localparam int EVENT_LEN       = 6;
  localparam int NUM_KEYS        = 5;

  typedef enum logic [1:0] {
    KR_IDLE,
    KR_DELAY,
    KR_REPEAT
  } kr_state_e;

endpackage

// File: rtl/game_event_generator_if.sv
// rtl/game_event_generator_if.sv - key/level inputs and event request/ack handshake
interface game_event_generator_if;
  import game_event_generator_pkg::*;

  logic                 enable;
  logic [1:0]           level;
  logic [NUM_KEYS-1:0]  key_held;
  logic [EVENT_LEN-1:0] event_received;
  logic [EVENT_LEN-1:0] event_out;

  modport master (
    input  enable,
    input  level,
    input  key_held,
    input  event_received,
    output event_out
  );

  modport slave (
    output enable,
    output level,
    output key_held,
    output event_received,
    input  event_out
  );

endinterface

// File: rtl/game_event_generator_key_repeat.sv
// rtl/game_event_generator_key_repeat.sv - per-key press/auto-repeat trigger generator
module key_repeat
  import game_event_generator_pkg::*;
#(
  parameter int REPEAT_DELAY  = 610,
  parameter int REPEAT_PERIOD = 153,
  parameter int CNT_W         = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic press,
  input  logic held,
  output logic trig
);

  kr_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] limit;
  logic             at_limit;

  assign limit    = (state_q == KR_DELAY) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
  assign at_limit = (cnt_q == limit);
  // Trigger is combinational so a press lands in event_out on the same edge it is sampled.
  assign trig     = enable & ((state_q == KR_IDLE) ? press : (held & at_limit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= KR_IDLE;
      cnt_q   <= '0;
    end else if (!enable || (state_q != KR_IDLE && !held)) begin
      state_q <= KR_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        KR_IDLE: begin
          if (press) begin
            state_q <= KR_DELAY;
            cnt_q   <= '0;
          end
        end
        KR_DELAY, KR_REPEAT: begin
          if (at_limit) begin
            state_q <= KR_REPEAT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= KR_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_event_generator.sv
// rtl/game_event_generator.sv - key edge detect, gravity timer and sticky pending-event register
module game_event_generator
  import game_event_generator_pkg::*;
#(
  parameter int FALL_PERIOD_L0 = 3052,
  parameter int FALL_PERIOD_L1 = 1526,
  parameter int FALL_PERIOD_L2 = 763,
  parameter int FALL_PERIOD_L3 = 381,
  parameter int REPEAT_DELAY   = 610,
  parameter int REPEAT_PERIOD  = 153,
  parameter int CNT_W          = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  game_event_generator_if.master evt
);

  localparam int REP_KEY [3] = '{EVENT_KEY_DOWN, EVENT_KEY_RIGHT, EVENT_KEY_LEFT};

  logic [NUM_KEYS-1:0]  key_prev_q;
  logic [NUM_KEYS-1:0]  press;
  logic [EVENT_LEN-1:0] event_out_q, event_out_d;
  logic [EVENT_LEN-1:0] trig;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]     fall_last;
  logic [1:0]           level_q, level_d, level_ref;
  logic                 init_q;
  logic                 trig_fall;

  assign press = evt.key_held & ~key_prev_q;

  // Until the first edge after reset the tracked level follows the input, so no spurious change is seen.
  assign level_ref = init_q ? level_q : evt.level;

  always_comb begin
    fall_last = CNT_W'(FALL_PERIOD_L0 - 1);
    case (level_ref)
      2'd1:    fall_last = CNT_W'(FALL_PERIOD_L1 - 1);
      2'd2:    fall_last = CNT_W'(FALL_PERIOD_L2 - 1);
      2'd3:    fall_last = CNT_W'(FALL_PERIOD_L3 - 1);
      default: fall_last = CNT_W'(FALL_PERIOD_L0 - 1);
    endcase
  end

  always_comb begin
    fcnt_d    = fcnt_q;
    level_d   = level_ref;
    trig_fall = 1'b0;
    if (evt.enable) begin
      if (evt.level != level_ref) begin
        fcnt_d  = '0;
        level_d = evt.level;
      end else if (fcnt_q == fall_last) begin
        trig_fall = 1'b1;
        fcnt_d    = '0;
      end else begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rep
    key_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_key_repeat (
      .clk   (clk),
      .rst   (rst),
      .enable(evt.enable),
      .press (press[REP_KEY[g]]),
      .held  (evt.key_held[REP_KEY[g]]),
      .trig  (trig[REP_KEY[g]])
    );
  end

  assign trig[EVENT_KEY_UP]    = press[EVENT_KEY_UP] & evt.enable;
  assign trig[EVENT_KEY_SPACE] = press[EVENT_KEY_SPACE] & evt.enable;
  assign trig[EVENT_FALL]      = trig_fall;

  // A new trigger wins over an ack in the same cycle.
  assign event_out_d = (event_out_q & ~evt.event_received) | trig;
  assign evt.event_out = event_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev_q  <= '0;
      event_out_q <= '0;
      fcnt_q      <= '0;
      level_q     <= '0;
      init_q      <= 1'b0;
    end else begin
      key_prev_q  <= evt.key_held;
      event_out_q <= event_out_d;
      fcnt_q      <= fcnt_d;
      level_q     <= level_d;
      init_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_event_generator.sv
// tb/tb_game_event_generator.sv - directed vector bench for game_event_generator
module tb_game_event_generator;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] lvl;
    logic [4:0] held;
    logic [5:0] ack;
    logic [5:0] exp_out;
    int         seg;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   seg_id;
  vec_t vecs[$];

  game_event_generator_if evt();

  game_event_generator #(
    .FALL_PERIOD_L0(8),
    .FALL_PERIOD_L1(6),
    .FALL_PERIOD_L2(4),
    .FALL_PERIOD_L3(2),
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (3),
    .CNT_W         (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .evt(evt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic en, input logic [1:0] lvl, input logic [4:0] held,
                     input logic [5:0] ack, input logic [5:0] exp_out, input int n);
    for (int i = 0; i < n; i++)
      vecs.push_back('{rst_n: r, en: en, lvl: lvl, held: held, ack: ack, exp_out: exp_out, seg: seg_id});
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s event_out got %h want %h", name, act, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    errors = 0;
    evt.enable = 1'b1;
    evt.level = 2'd0;
    evt.key_held = '0;
    evt.event_received = '0;

    // seg 1: gravity at level 0, acks of non-pending bits ignored
    seg_id = 1;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h00, 6'h01, 6'h00, 7);
    add(1, 1, 0, 5'h00, 6'h00, 6'h20, 2);
    add(1, 1, 0, 5'h00, 6'h20, 6'h00, 1);
    add(1, 1, 0, 5'h00, 6'h00, 6'h00, 5);
    add(1, 1, 0, 5'h00, 6'h00, 6'h20, 1);
    // seg 2: level sampled at reset, first FALL after 4 edges
    seg_id = 2;
    add(0, 1, 2, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 2, 5'h00, 6'h00, 6'h00, 3);
    add(1, 1, 2, 5'h00, 6'h00, 6'h20, 1);
    // seg 3: UP held gives one event only
    seg_id = 3;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h01, 6'h20, 6'h01, 6);
    add(1, 1, 0, 5'h01, 6'h21, 6'h00, 1);
    add(1, 1, 0, 5'h01, 6'h20, 6'h20, 1);
    add(1, 1, 0, 5'h01, 6'h20, 6'h00, 4);
    add(1, 1, 0, 5'h00, 6'h20, 6'h00, 1);
    add(1, 1, 0, 5'h01, 6'h20, 6'h01, 1);
    // seg 4: LEFT auto-repeat at edges 1, 6, 9, 12, 15
    seg_id = 4;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h28, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h00, 3);
    add(1, 1, 0, 5'h08, 6'h20, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h28, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h20, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h28, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h28, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h20, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h28, 6'h20, 1);
    add(1, 1, 0, 5'h00, 6'h20, 6'h00, 4);
    // seg 5: DOWN ack/retrigger collision, coalescing, simultaneous presses
    seg_id = 5;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h02, 6'h20, 6'h02, 5);
    add(1, 1, 0, 5'h02, 6'h22, 6'h02, 1);
    add(1, 1, 0, 5'h02, 6'h20, 6'h02, 1);
    add(1, 1, 0, 5'h02, 6'h20, 6'h22, 1);
    add(1, 1, 0, 5'h02, 6'h20, 6'h02, 1);
    add(1, 1, 0, 5'h02, 6'h22, 6'h00, 1);
    add(1, 1, 0, 5'h00, 6'h22, 6'h00, 1);
    add(1, 1, 0, 5'h1F, 6'h20, 6'h1F, 1);
    // seg 6: level 0 -> 3 at fcnt 6
    seg_id = 6;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h00, 6'h00, 6'h00, 6);
    add(1, 1, 3, 5'h00, 6'h00, 6'h00, 2);
    add(1, 1, 3, 5'h00, 6'h00, 6'h20, 1);
    add(1, 1, 3, 5'h00, 6'h20, 6'h00, 1);
    add(1, 1, 3, 5'h00, 6'h00, 6'h20, 1);
    add(1, 1, 3, 5'h00, 6'h20, 6'h00, 1);
    add(1, 1, 3, 5'h00, 6'h00, 6'h20, 1);
    // seg 7: 20-cycle pause with keys held, then LEFT re-pressed into repeat
    seg_id = 7;
    add(0, 1, 0, 5'h00, 6'h00, 6'h00, 1);
    add(1, 1, 0, 5'h09, 6'h00, 6'h09, 1);
    add(1, 0, 0, 5'h0B, 6'h00, 6'h09, 3);
    add(1, 0, 0, 5'h0B, 6'h01, 6'h08, 1);
    add(1, 0, 0, 5'h0B, 6'h00, 6'h08, 16);
    add(1, 1, 0, 5'h0B, 6'h00, 6'h08, 6);
    add(1, 1, 0, 5'h0B, 6'h00, 6'h28, 1);
    add(1, 1, 0, 5'h0B, 6'h08, 6'h20, 1);
    add(1, 1, 0, 5'h00, 6'h20, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h00, 6'h08, 1);
    add(1, 1, 0, 5'h08, 6'h08, 6'h00, 1);
    add(1, 1, 0, 5'h08, 6'h00, 6'h00, 3);
    add(1, 1, 0, 5'h08, 6'h00, 6'h28, 2);

    foreach (vecs[i]) begin
      rst = vecs[i].rst_n;
      evt.enable = vecs[i].en;
      evt.level = vecs[i].lvl;
      evt.key_held = vecs[i].held;
      evt.event_received = vecs[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_seg%0d", i, vecs[i].seg), evt.event_out, vecs[i].exp_out);
    end

    // Asynchronous reset mid-repeat clears pending events without a clock edge.
    evt.event_received = '0;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_clear", evt.event_out, 6'h00);
    @(posedge clk);
    #1;
    check("held_in_reset", evt.event_out, 6'h00);
    rst = 1'b1;
    evt.key_held = 5'h08;
    @(posedge clk);
    #1;
    check("left_fresh_after_reset", evt.event_out, 6'h08);
    @(posedge clk);
    #1;
    check("left_pending_hold", evt.event_out, 6'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
